// File: rtl/crypt_sequencer.sv
// crypt_sequencer: transaction controller for the serial XOR-encryption datapath.
// Routes host bits to the key/message deserializers, waits for the encrypt stage,
// counts ciphertext bits leaving the serializer and reports done / timeout / abort.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 global enable; all registers hold while low
//   iStart, iSkip_key   start a transaction (IDLE only), optionally skipping the key load
//   iAbort              cancel the current transaction (ignored in IDLE)
//   iHost_valid/bit     host serial stream; oHost_ready accepts it in the load states
//   oData_bit           registered bit forwarded to the deserializers
//   oKey_flag/oMsg_flag registered deserializer load flags
//   iEnc_done           completion pulse from the encrypt stage
//   iCt_flag            serializer output-valid, one per ciphertext bit
//   oBusy, oDone        not-IDLE indicator, one-cycle completion pulse
//   oTimeout            sticky stall indicator, cleared by the next accepted start
//   oState              current state encoding
module crypt_sequencer #(
    parameter int unsigned MSG_SIZE = 64,
    parameter int unsigned KEY_SIZE = 8,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       iStart,
    input  logic       iSkip_key,
    input  logic       iAbort,
    input  logic       iHost_valid,
    input  logic       iHost_bit,
    output logic       oHost_ready,
    output logic       oData_bit,
    output logic       oKey_flag,
    output logic       oMsg_flag,
    input  logic       iEnc_done,
    input  logic       iCt_flag,
    output logic       oBusy,
    output logic       oDone,
    output logic       oTimeout,
    output logic [2:0] oState
);

    localparam int unsigned CNT_W = $clog2(MSG_SIZE) + 1;
    localparam int unsigned TMR_W = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_KEY = 3'd1,
        S_LOAD_MSG = 3'd2,
        S_ENCRYPT  = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [TMR_W-1:0]   tmr_inc_c;
    logic               data_q, data_d;
    logic               key_flag_q, key_flag_d;
    logic               msg_flag_q, msg_flag_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               accept_c;

    // Status decoded straight from the state register
    assign oHost_ready = (state_q == S_LOAD_KEY) || (state_q == S_LOAD_MSG);
    assign oBusy       = (state_q != S_IDLE);
    assign oState      = 3'(state_q);
    assign oData_bit   = data_q;
    assign oKey_flag   = key_flag_q;
    assign oMsg_flag   = msg_flag_q;
    assign oDone       = done_q;
    assign oTimeout    = timeout_q;

    assign accept_c  = iHost_valid && oHost_ready;
    assign tmr_inc_c = tmr_q + TMR_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tmr_q      <= '0;
            data_q     <= 1'b0;
            key_flag_q <= 1'b0;
            msg_flag_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (ena) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            data_q     <= data_d;
            key_flag_q <= key_flag_d;
            msg_flag_q <= msg_flag_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        data_d     = data_q;
        key_flag_d = 1'b0;
        msg_flag_d = 1'b0;
        timeout_d  = timeout_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    tmr_d     = '0;
                    state_d   = iSkip_key ? S_LOAD_MSG : S_LOAD_KEY;
                end
            end
            S_LOAD_KEY: begin
                if (accept_c) begin
                    data_d     = iHost_bit;
                    key_flag_d = 1'b1;
                    if (cnt_q == CNT_W'(KEY_SIZE - 1)) begin
                        state_d = S_LOAD_MSG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_MSG: begin
                if (accept_c) begin
                    data_d     = iHost_bit;
                    msg_flag_d = 1'b1;
                    if (cnt_q == CNT_W'(MSG_SIZE - 1)) begin
                        state_d = S_ENCRYPT;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ENCRYPT: begin
                // A completion arriving on the last stall cycle still wins
                if (iEnc_done) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end else if (tmr_inc_c == TMR_W'(TIMEOUT)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    tmr_d     = '0;
                end else begin
                    tmr_d = tmr_inc_c;
                end
            end
            S_DRAIN: begin
                if (iCt_flag) begin
                    tmr_d = '0;
                    if (cnt_q == CNT_W'(MSG_SIZE - 1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tmr_inc_c == TMR_W'(TIMEOUT)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    tmr_d     = '0;
                end else begin
                    tmr_d = tmr_inc_c;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tmr_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tmr_d   = '0;
            end
        endcase

        // Abort overrides every same-cycle event outside IDLE
        if (iAbort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            tmr_d      = '0;
            data_d     = data_q;
            key_flag_d = 1'b0;
            msg_flag_d = 1'b0;
            timeout_d  = timeout_q;
        end

        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_crypt_sequencer.sv
// Scoreboard bench for crypt_sequencer: the driver pushes expected flag and
// end-of-transaction events; a negedge monitor pops and compares them.
module tb_crypt_sequencer;

    localparam int MSG_SIZE = 64;
    localparam int KEY_SIZE = 8;
    localparam int TIMEOUT  = 255;

    localparam int K_KEY     = 0;
    localparam int K_MSG     = 1;
    localparam int K_DONE    = 2;
    localparam int K_TIMEOUT = 3;
    localparam int K_ABORT   = 4;

    logic       clk, rst_n, ena;
    logic       iStart, iSkip_key, iAbort, iHost_valid, iHost_bit;
    logic       oHost_ready, oData_bit, oKey_flag, oMsg_flag;
    logic       iEnc_done, iCt_flag;
    logic       oBusy, oDone, oTimeout;
    logic [2:0] oState;

    crypt_sequencer #(.MSG_SIZE(MSG_SIZE), .KEY_SIZE(KEY_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .iStart(iStart), .iSkip_key(iSkip_key), .iAbort(iAbort),
        .iHost_valid(iHost_valid), .iHost_bit(iHost_bit),
        .oHost_ready(oHost_ready), .oData_bit(oData_bit),
        .oKey_flag(oKey_flag), .oMsg_flag(oMsg_flag),
        .iEnc_done(iEnc_done), .iCt_flag(iCt_flag),
        .oBusy(oBusy), .oDone(oDone), .oTimeout(oTimeout), .oState(oState)
    );

    typedef struct {
        int   kind;
        logic b;
        int   cyc;
    } exp_t;

    exp_t flag_q[$];
    exp_t end_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic logic [63:0] pack(input int kind, input logic b, input int c);
        return {23'd0, 8'(kind), b, 32'(c)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every flag pulse and every end of transaction
    initial begin
        logic prev_busy, prev_done, prev_to;
        exp_t e;
        int   k;
        prev_busy = 1'b0; prev_done = 1'b0; prev_to = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (oKey_flag && oMsg_flag)
                    fail_now("both_flags_high");
                if (oKey_flag || oMsg_flag) begin
                    if (flag_q.size() == 0) begin
                        fail_now("unexpected_flag");
                    end else begin
                        e = flag_q.pop_front();
                        check("flag_event", pack(oKey_flag ? K_KEY : K_MSG, oData_bit, cyc),
                              pack(e.kind, e.b, e.cyc));
                    end
                end
                if (prev_busy && !oBusy) begin
                    k = prev_done ? K_DONE : ((oTimeout && !prev_to) ? K_TIMEOUT : K_ABORT);
                    if (end_q.size() == 0) begin
                        fail_now("unexpected_end");
                    end else begin
                        e = end_q.pop_front();
                        check("end_event", pack(k, 1'b0, cyc), pack(e.kind, 1'b0, e.cyc));
                    end
                end
            end
            prev_busy = oBusy;
            prev_done = oDone;
            prev_to   = oTimeout;
        end
    end

    task automatic start_txn(input logic skip, input logic with_abort);
        iStart = 1'b1; iSkip_key = skip; iAbort = with_abort;
        step();
        iStart = 1'b0; iAbort = 1'b0;
        check("start", {oBusy, oHost_ready, oTimeout, oState},
              {1'b1, 1'b1, 1'b0, (skip ? 3'd2 : 3'd1)});
    endtask

    // Host bit stream; the model knows how many bits each phase takes
    task automatic load_bits(input int nkey, input int mode, input bit abort_key, output int last_edge);
        int   got   = 0;
        int   total = nkey + MSG_SIZE;
        int   guard = 0;
        logic v, b;
        last_edge = 0;
        while (got < total && guard < 1000) begin
            guard++;
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = ((guard % 2) == 0);
            else                v = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            iHost_valid = v;
            iHost_bit   = b;
            iStart      = (got >= nkey) && ($urandom_range(0, 3) == 0);
            if (v) begin
                if (abort_key && got == nkey - 1) begin
                    iAbort = 1'b1;
                    end_q.push_back('{K_ABORT, 1'b0, cyc + 1});
                    step();
                    iAbort = 1'b0; iHost_valid = 1'b0; iStart = 1'b0;
                    check("abort_key_state", {oState, oDone, oKey_flag}, {3'd0, 1'b0, 1'b0});
                    return;
                end
                flag_q.push_back('{(got < nkey) ? K_KEY : K_MSG, b, cyc + 1});
                got++;
                if (got == total) last_edge = cyc + 1;
            end
            step();
        end
        iHost_valid = 1'b0; iStart = 1'b0;
        if (guard >= 1000) fail_now("load_bound");
        check("ready_falls", {oState, oHost_ready}, {3'd3, 1'b0});
    endtask

    task automatic enc_done_after(input int idle);
        repeat (idle) step();
        iEnc_done = 1'b1;
        step();
        iEnc_done = 1'b0;
        check("enter_drain", oState, 3'd4);
    endtask

    task automatic drain(input bit abort_last, input int gap_at, input int enc_pulse_at);
        int n = 0;
        bit gap_done = 1'b0;
        while (n < MSG_SIZE) begin
            if (!gap_done && n == gap_at) begin
                gap_done = 1'b1;
                ena = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    iCt_flag  = 1'($urandom_range(0, 1));
                    iEnc_done = (i == 3);
                    step();
                    check("ena_hold", {oState, oBusy, oDone, oKey_flag, oMsg_flag, oHost_ready},
                          {3'd4, 1'b1, 4'b0});
                end
                ena = 1'b1; iCt_flag = 1'b0; iEnc_done = 1'b0;
            end
            repeat ($urandom_range(0, 3)) step();
            iCt_flag  = 1'b1;
            iEnc_done = (n == enc_pulse_at);
            if (n == MSG_SIZE - 1) begin
                if (abort_last) begin
                    iAbort = 1'b1;
                    end_q.push_back('{K_ABORT, 1'b0, cyc + 1});
                end else begin
                    end_q.push_back('{K_DONE, 1'b0, cyc + 2});
                end
            end
            step();
            n++;
            iCt_flag = 1'b0; iEnc_done = 1'b0; iAbort = 1'b0;
        end
        if (abort_last) begin
            check("abort_ct", {oState, oDone}, {3'd0, 1'b0});
        end else begin
            check("done_pulse", {oState, oDone}, {3'd5, 1'b1});
            step();
            check("done_to_idle", {oState, oDone, oBusy}, {3'd0, 1'b0, 1'b0});
        end
        repeat (2) step();
    endtask

    initial begin
        int le;
        int w;
        rst_n = 1'b0; ena = 1'b1; iStart = 1'b1; iSkip_key = 1'b0; iAbort = 1'b0;
        iHost_valid = 1'b1; iHost_bit = 1'b1; iEnc_done = 1'b0; iCt_flag = 1'b0;

        // Reset holds everything at zero despite active inputs
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_vals", {oState, oBusy, oHost_ready, oData_bit, oKey_flag, oMsg_flag, oDone, oTimeout},
                  10'd0);
        end
        iStart = 1'b0; iHost_valid = 1'b0; iHost_bit = 1'b0;
        rst_n = 1'b1;
        repeat (2) step();

        // Full transaction, every cycle valid
        start_txn(1'b0, 1'b0);
        load_bits(KEY_SIZE, 0, 1'b0, le);
        enc_done_after(5);
        drain(1'b0, -1, -1);

        // Skip key, toggled valid, ena gap mid-drain, stray iEnc_done in DRAIN
        start_txn(1'b1, 1'b0);
        load_bits(0, 1, 1'b0, le);
        enc_done_after(20);
        drain(1'b0, 30, 12);

        // No encrypt completion: timeout
        start_txn(1'b0, 1'b0);
        load_bits(KEY_SIZE, 2, 1'b0, le);
        end_q.push_back('{K_TIMEOUT, 1'b0, le + TIMEOUT});
        w = 0;
        while (oBusy && w < 400) begin
            step();
            w++;
        end
        if (w >= 400) fail_now("timeout_bound");
        check("timeout_sticky", {oTimeout, oDone, oState}, {1'b1, 1'b0, 3'd0});
        repeat (3) step();
        check("timeout_holds", oTimeout, 1'b1);

        // Start with abort in IDLE (start wins); clears timeout; abort on last ct
        start_txn(1'b1, 1'b1);
        load_bits(0, 0, 1'b0, le);
        enc_done_after(1);
        drain(1'b1, -1, -1);

        // Abort on the last key bit
        start_txn(1'b0, 1'b0);
        load_bits(KEY_SIZE, 0, 1'b1, le);
        repeat (2) step();

        // Random-valid transaction to completion
        start_txn(1'b0, 1'b0);
        load_bits(KEY_SIZE, 2, 1'b0, le);
        enc_done_after(0);
        drain(1'b0, -1, 40);

        // Asynchronous reset mid-load
        start_txn(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {oState, oBusy, oHost_ready, oKey_flag, oMsg_flag, oDone, oTimeout}, 9'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        check("flag_queue_empty", 32'(flag_q.size()), 32'd0);
        check("end_queue_empty", 32'(end_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
